// File: rtl/cmd_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cmd_scheduler
// Brief    : Replays host-preloaded, timestamped register writes on an
//            internal command bus when a free-running timebase reaches them.
// Revision : 1.0
// ============================================================================
module cmd_scheduler #(
    parameter int POSITION = 300,
    parameter int DEPTH    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [18:0] addr,
    input  logic        data_wr,
    input  logic [15:0] data_in,
    input  logic        data_rd,
    output logic [15:0] data_out,
    output logic [18:0] cmd_addr,
    output logic [15:0] cmd_data,
    output logic        cmd_wr,
    output logic        busy
);
    localparam int          PW     = $clog2(DEPTH);
    localparam logic [18:0] C_BASE = 19'(POSITION);
    localparam logic [18:0] C_END  = 19'(POSITION + 8);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_wr_hit_d, r_rd_hit_d;
    logic        w_in_win, w_wr_hit, w_rd_hit, w_wr_stb, w_rd_stb;
    logic [2:0]  w_off;
    logic        w_push, w_push_ok, w_pop, w_ctrl_wr, w_flush, w_clr, w_due, w_late_evt;
    logic        r_run, r_ovf, r_late, r_busy;
    logic [15:0] r_stg_addr, r_stg_data, r_stg_tlo, r_time_hi;
    logic [31:0] r_tb;
    logic [66:0] r_mem [DEPTH];
    logic [PW:0] r_wptr, r_rptr, w_count;
    logic        w_empty, w_full;
    logic [7:0]  w_count8;
    logic [66:0] w_head;
    logic [18:0] w_head_addr, r_last_addr;
    logic [15:0] w_head_data, r_last_data;
    logic [31:0] w_head_time;

    // Bus decode: one register access per rising edge of the qualified strobe
    assign w_in_win  = (addr >= C_BASE) && (addr < C_END);
    assign w_off     = 3'(addr - C_BASE);
    assign w_wr_hit  = enable & data_wr & w_in_win;
    assign w_rd_hit  = enable & data_rd & w_in_win;
    assign w_wr_stb  = w_wr_hit & ~r_wr_hit_d;
    assign w_rd_stb  = w_rd_hit & ~r_rd_hit_d;
    assign w_push    = w_wr_stb && (w_off == 3'd3);
    assign w_ctrl_wr = w_wr_stb && (w_off == 3'd4);
    assign w_flush   = w_ctrl_wr & data_in[1];
    assign w_clr     = w_ctrl_wr & data_in[2];

    assign w_count  = r_wptr - r_rptr;
    assign w_count8 = 8'(w_count);
    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);

    assign w_head      = r_mem[r_rptr[PW-1:0]];
    assign w_head_addr = w_head[66:48];
    assign w_head_data = w_head[47:32];
    assign w_head_time = w_head[31:0];

    assign w_pop      = (r_state == S_ISSUE) & ~w_flush;
    assign w_push_ok  = w_push & (~w_full | w_pop);
    assign w_late_evt = w_pop && (r_tb > w_head_time);
    // Look one tick ahead so the strobe lands on the cycle the timebase equals the stamp
    assign w_due      = r_run & ~w_empty & ((r_tb + 32'd1) >= w_head_time);

    assign cmd_wr   = w_pop;
    assign cmd_addr = w_pop ? w_head_addr : r_last_addr;
    assign cmd_data = w_pop ? w_head_data : r_last_data;
    assign busy     = r_busy;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr[PW-1:0]] <= {3'b000, r_stg_addr, r_stg_data, data_in, r_stg_tlo};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_hit_d  <= 1'b0;
            r_rd_hit_d  <= 1'b0;
            r_stg_addr  <= '0;
            r_stg_data  <= '0;
            r_stg_tlo   <= '0;
            r_run       <= 1'b0;
            r_time_hi   <= '0;
            r_busy      <= 1'b0;
            r_last_addr <= '0;
            r_last_data <= '0;
        end else begin
            r_wr_hit_d <= w_wr_hit;
            r_rd_hit_d <= w_rd_hit;
            r_busy     <= r_run & ~w_empty;
            if (w_wr_stb && (w_off == 3'd0)) r_stg_addr <= data_in;
            if (w_wr_stb && (w_off == 3'd1)) r_stg_data <= data_in;
            if (w_wr_stb && (w_off == 3'd2)) r_stg_tlo  <= data_in;
            if (w_ctrl_wr)                   r_run      <= data_in[0];
            if (w_rd_stb && (w_off == 3'd6)) r_time_hi  <= r_tb[31:16];
            if (w_pop) begin
                r_last_addr <= w_head_addr;
                r_last_data <= w_head_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_tb   <= '0;
            r_ovf  <= 1'b0;
            r_late <= 1'b0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop)     r_rptr <= r_rptr + 1'b1;
            if (r_run)     r_tb   <= r_tb + 32'd1;
            if (w_clr) begin
                r_ovf  <= 1'b0;
                r_late <= 1'b0;
            end else begin
                if (w_push & ~w_push_ok) r_ovf  <= 1'b1;
                if (w_late_evt)          r_late <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // GAP re-evaluates the next head so back-to-back due commands stay 2 cycles apart
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_due) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_GAP;
            S_GAP:   w_state_nxt = w_due ? S_ISSUE : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_flush) w_state_nxt = S_IDLE;
    end

    always_comb begin
        data_out = 16'h0000;
        if (w_rd_hit) begin
            case (w_off)
                3'd4:    data_out = {15'b0, r_run};
                3'd5:    data_out = {4'b0, r_late, r_ovf, w_empty, w_full, w_count8};
                3'd6:    data_out = r_tb[15:0];
                3'd7:    data_out = r_time_hi;
                default: data_out = 16'h0000;
            endcase
        end
    end

endmodule
`default_nettype wire
